// File: rtl/accumulator_bank.sv
// accumulator_bank: banked per-lane accumulator storage for systolic-array outputs.
// Ports:
//   clk_i, rst_i (async, active-low)
//   mac_data_i            LANES x ACC_W lane values, lane k at [k*ACC_W +: ACC_W]
//   write_accumulator_i   write strobe; accumulator_addr_wr_i row; accum_addr_mask_i per-lane
//                         enable (bit LANES-1-k enables lane k); accumulator_add_i 1=add, 0=overwrite
//   rd_req_i, rd_addr_i   readout request and row
//   rd_valid_o, rd_data_o readout response one cycle after the request
//   busy_o                high while the array is being cleared
//   err_o                 sticky: request while busy, or row out of range
module accumulator_bank #(
    parameter int LANES = 32,
    parameter int DEPTH = 128,
    parameter int ACC_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [LANES*ACC_W-1:0] mac_data_i,
    input  logic                   write_accumulator_i,
    input  logic [6:0]             accumulator_addr_wr_i,
    input  logic [LANES-1:0]       accum_addr_mask_i,
    input  logic                   accumulator_add_i,
    input  logic                   rd_req_i,
    input  logic [6:0]             rd_addr_i,
    output logic                   rd_valid_o,
    output logic [LANES*ACC_W-1:0] rd_data_o,
    output logic                   busy_o,
    output logic                   err_o
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int RW = LANES * ACC_W;
    localparam logic [7:0] DEPTH_L = 8'(DEPTH);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state;
    logic [AW-1:0]   clr_cnt;
    logic [RW-1:0]   mem [DEPTH];
    logic            s1_vld;
    logic [AW-1:0]   s1_addr;
    logic [LANES-1:0] s1_mask;
    logic            s1_add;
    logic [RW-1:0]   s1_mac;
    logic [RW-1:0]   s1_old;
    logic [RW-1:0]   s1_new;
    logic            wr_oob, rd_oob, wr_ok, rd_go, req_err;
    logic [AW-1:0]   wr_row, rd_row;
    logic [RW-1:0]   wr_old, rd_cur;

    assign busy_o  = state == CLEAR;
    assign wr_row  = accumulator_addr_wr_i[AW-1:0];
    assign rd_row  = rd_addr_i[AW-1:0];
    assign wr_oob  = {1'b0, accumulator_addr_wr_i} >= DEPTH_L;
    assign rd_oob  = {1'b0, rd_addr_i} >= DEPTH_L;
    assign wr_ok   = write_accumulator_i && !busy_o && !wr_oob;
    assign rd_go   = rd_req_i && !busy_o;
    assign req_err = busy_o ? (write_accumulator_i || rd_req_i)
                            : ((write_accumulator_i && wr_oob) || (rd_req_i && rd_oob));

    // The stage-1 write has not reached the array yet, so a same-row access
    // in the following cycle must take its result instead of the stored row.
    assign wr_old = (s1_vld && s1_addr == wr_row) ? s1_new : mem[wr_row];
    assign rd_cur = rd_oob ? '0 : (s1_vld && s1_addr == rd_row) ? s1_new : mem[rd_row];

    // Masked-off lanes pass the old row through untouched.
    always_comb begin
        s1_new = s1_old;
        for (int k = 0; k < LANES; k++)
            if (s1_mask[LANES-1-k])
                s1_new[k*ACC_W +: ACC_W] = s1_add ? s1_old[k*ACC_W +: ACC_W] + s1_mac[k*ACC_W +: ACC_W]
                                                  : s1_mac[k*ACC_W +: ACC_W];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            s1_vld     <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            err_o      <= 1'b0;
        end else begin
            if (busy_o) begin
                clr_cnt <= clr_cnt + AW'(1);
                if (clr_cnt == AW'(DEPTH - 1))
                    state <= RUN;
            end
            s1_vld     <= wr_ok;
            rd_valid_o <= rd_go;
            if (rd_go)
                rd_data_o <= rd_cur;
            if (req_err)
                err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            s1_addr <= wr_row;
            s1_mask <= accum_addr_mask_i;
            s1_add  <= accumulator_add_i;
            s1_mac  <= mac_data_i;
            s1_old  <= wr_old;
        end
    end

    // The clear sweep owns the write port; no stage-1 write can be pending then.
    always_ff @(posedge clk_i) begin
        if (busy_o)
            mem[clr_cnt] <= '0;
        else if (s1_vld)
            mem[s1_addr] <= s1_new;
    end
endmodule

// File: tb/tb_accumulator_bank.sv
// tb_accumulator_bank: randomized scoreboard bench for accumulator_bank against a per-lane array model.
module tb_accumulator_bank;
    localparam int L = 32;
    localparam int D = 128;
    localparam int W = 32;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic [L*W-1:0] mac_data_i = '0;
    logic           write_accumulator_i = 1'b0;
    logic [6:0]     accumulator_addr_wr_i = '0;
    logic [L-1:0]   accum_addr_mask_i = '0;
    logic           accumulator_add_i = 1'b0;
    logic           rd_req_i = 1'b0;
    logic [6:0]     rd_addr_i = '0;
    logic           rd_valid_o;
    logic [L*W-1:0] rd_data_o;
    logic           busy_o;
    logic           err_o;

    accumulator_bank #(.LANES(L), .DEPTH(D), .ACC_W(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .mac_data_i(mac_data_i),
        .write_accumulator_i(write_accumulator_i), .accumulator_addr_wr_i(accumulator_addr_wr_i),
        .accum_addr_mask_i(accum_addr_mask_i), .accumulator_add_i(accumulator_add_i),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_valid_o(rd_valid_o),
        .rd_data_o(rd_data_o), .busy_o(busy_o), .err_o(err_o));

    always #5 clk_i = ~clk_i;

    typedef struct {
        int             row;
        logic [L*W-1:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [W-1:0] model [D][L];
    int         tests = 0;
    int         fails = 0;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %0h exp %0h", name, got, want);
        end
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < D; r++)
            for (int k = 0; k < L; k++)
                model[r][k] = '0;
    endfunction

    // One bus cycle; the model takes the read before the same-cycle write.
    task automatic cyc(input bit we, input int wa, input logic [L-1:0] m, input bit add,
                       input logic [L*W-1:0] d, input bit re, input int ra);
        exp_t e;
        write_accumulator_i   = we;
        accumulator_addr_wr_i = 7'(wa);
        accum_addr_mask_i     = m;
        accumulator_add_i     = add;
        mac_data_i            = d;
        rd_req_i              = re;
        rd_addr_i             = 7'(ra);
        if (!busy_o) begin
            if (re) begin
                e.row = ra;
                for (int k = 0; k < L; k++)
                    e.data[k*W +: W] = model[ra][k];
                exp_q.push_back(e);
            end
            if (we)
                for (int k = 0; k < L; k++)
                    if (m[L-1-k])
                        model[wa][k] = add ? model[wa][k] + d[k*W +: W] : d[k*W +: W];
        end
        @(negedge clk_i);
        write_accumulator_i = 1'b0;
        rd_req_i            = 1'b0;
    endtask

    task automatic rd(input int ra);
        cyc(1'b0, 0, '0, 1'b0, '0, 1'b1, ra);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_clear(input int err_cycle, output int n);
        n = 0;
        while (busy_o && n < 300) begin
            if (n == err_cycle) begin
                write_accumulator_i   = 1'b1;
                accumulator_addr_wr_i = 7'd20;
                accum_addr_mask_i     = '1;
                accumulator_add_i     = 1'b0;
                mac_data_i            = {L{32'd5}};
                rd_req_i              = 1'b1;
                rd_addr_i             = 7'd20;
            end else begin
                write_accumulator_i = 1'b0;
                rd_req_i            = 1'b0;
            end
            @(negedge clk_i);
            n++;
        end
        write_accumulator_i = 1'b0;
        rd_req_i            = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (rd_valid_o) begin
            exp_t e;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rd_unexpected got valid=1 exp no response");
            end else begin
                e = exp_q.pop_front();
                if (rd_data_o !== e.data) begin
                    fails++;
                    for (int k = 0; k < L; k++)
                        if (rd_data_o[k*W +: W] !== e.data[k*W +: W]) begin
                            $display("FAIL rd_data row %0d lane %0d got %h exp %h",
                                     e.row, k, rd_data_o[k*W +: W], e.data[k*W +: W]);
                            break;
                        end
                end
            end
        end
    end

    initial begin
        int             n;
        logic [L*W-1:0] d;
        logic [L-1:0]   m;
        model_clear();
        #2 rst_i = 1'b0;
        #1;
        check("reset_rd_valid", 64'(rd_valid_o), 64'd0);
        check("reset_rd_data_zero", 64'(rd_data_o == '0), 64'd1);
        check("reset_busy", 64'(busy_o), 64'd1);
        check("reset_err", 64'(err_o), 64'd0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        wait_clear(9, n);
        check("clear_cycles", 64'(n), 64'd128);
        check("err_after_busy_req", 64'(err_o), 64'd1);

        rd(5);
        rd(20);
        drain();

        d = '0;
        for (int k = 0; k < L; k++) d[k*W +: W] = $urandom;
        d[0 +: W] = 32'd7;
        cyc(1'b1, 3, 32'h80000000, 1'b0, d, 1'b0, 0);
        rd(3);

        cyc(1'b1, 10, '1, 1'b0, {L{32'd1}}, 1'b0, 0);
        cyc(1'b1, 10, '1, 1'b1, {L{32'd2}}, 1'b0, 0);
        rd(10);

        m = '0;
        m[L-1-5] = 1'b1;
        d = '0;
        d[5*W +: W] = 32'h7FFFFFFF;
        cyc(1'b1, 0, m, 1'b0, d, 1'b0, 0);
        d[5*W +: W] = 32'd1;
        cyc(1'b1, 0, m, 1'b1, d, 1'b0, 0);
        rd(0);
        drain();

        for (int r = 0; r < 32; r++) begin
            m = ~(32'hFFFFFFFF >> (r + 1));
            cyc(1'b1, r, m, 1'b1, {L{32'd1}}, 1'b0, 0);
        end
        for (int r = 0; r < 32; r++) begin
            m = 32'h7FFFFFFF >> r;
            cyc(1'b1, 32 + r, m, 1'b1, {L{32'd1}}, 1'b0, 0);
        end
        for (int r = 0; r < 64; r++) rd(r);
        drain();

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < L; k++) d[k*W +: W] = $urandom;
            m = $urandom;
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, 7), m, 1'($urandom_range(0, 1)), d,
                1'($urandom_range(0, 1)), $urandom_range(0, 7));
        end
        for (int r = 0; r < 8; r++) rd(r);
        drain();
        check("err_sticky", 64'(err_o), 64'd1);

        cyc(1'b1, 7, '1, 1'b0, {L{32'd9}}, 1'b0, 0);
        rst_i = 1'b0;
        #1;
        check("midreset_rd_valid", 64'(rd_valid_o), 64'd0);
        check("midreset_busy", 64'(busy_o), 64'd1);
        check("midreset_err_cleared", 64'(err_o), 64'd0);
        model_clear();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        wait_clear(-1, n);
        check("reclear_cycles", 64'(n), 64'd128);
        rd(7);
        rd(3);
        drain();
        check("err_clean_run", 64'(err_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
